fetch_queue: RTL

- IF-side instruction fetch unit with prefetch buffer, directly upstream of the decode (ID) stage.
- Owns the PC register and issues word reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned {pc, ir} pairs in a small FIFO and hands them to ID over a valid/ready handshake.
- On a taken branch/jump resolved downstream, flushes all buffered and in-flight fetches and restarts at the target.

---
 rtl/fetch_queue.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch unit: owns the PC, issues reads to a 1-cycle imem and buffers {pc, ir} for ID.
// Optional build macro FETCH_QUEUE_BYPASS_EN forwards a response straight to ID when the queue is empty.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic [31:0] out_ir
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic          inflight;
    logic [31:0]   q_pc [DEPTH];
    logic [31:0]   q_ir [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic          q_nonempty;
    logic          resp_valid;
    logic [CW:0]   occupancy;
    logic          bypass;
    logic          push;
    logic          pop;

    assign q_nonempty = (count != '0);
    assign resp_valid = inflight && !redirect;

    // The in-flight read holds a credit so its response always finds a free slot.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_en   = rst && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = pc[31:2];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = !q_nonempty && resp_valid;
`else
    assign bypass = 1'b0;
`endif

    // Handshake: a transfer to ID happens on a cycle with out_valid && out_ready;
    // while out_valid && !out_ready the head is held unchanged.
    always_comb begin
        out_valid = q_nonempty;
        out_pc    = q_pc[head];
        out_ir    = q_ir[head];
        if (bypass) begin
            out_valid = 1'b1;
            out_pc    = resp_pc;
            out_ir    = imem_data;
        end
    end

    assign out_pc4 = out_pc + 32'd4;

    assign pop  = q_nonempty && out_ready && !redirect;
    assign push = resp_valid && !(bypass && out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            resp_pc  <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                pc      <= pc + 32'd4;
                resp_pc <= pc;
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            if (push) begin
                tail <= tail + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i] <= '0;
                q_ir[i] <= '0;
            end
        end else if (push) begin
            q_pc[tail] <= resp_pc;
            q_ir[tail] <= imem_data;
        end
    end

endmodule
